// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the RGB pixel stream: pixel width, default image size,
// capture FSM states and {R,G,B} packing order.
package pixel_stream_pkg;

    localparam int PIX_W = 24;
    localparam int IMG_W = 768;
    localparam int IMG_H = 512;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic logic [PIX_W-1:0] pack_rgb(input logic [7:0] r,
                                                   input logic [7:0] g,
                                                   input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one registered read-first read port.
// The array has no reset; contents are undefined until written.
module frame_ram #(
    parameter int DEPTH = 12,
    parameter int AW    = 4,
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] q_r;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port; sampling the array on the write edge gives read-first behaviour
    always_ff @(posedge clk) begin
        if (re) begin
            q_r <= mem_r[raddr];
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pixel_frame_capture.sv
// Captures one raster-order RGB frame into a bottom-up (BMP order) frame buffer
// and exposes a registered random-access read port.
module pixel_frame_capture
    import pixel_stream_pkg::*;
#(
    parameter int WIDTH  = IMG_W,
    parameter int HEIGHT = IMG_H,
    parameter int AW     = $clog2(WIDTH*HEIGHT)
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             hsync,
    input  logic [7:0]       DATA_R,
    input  logic [7:0]       DATA_G,
    input  logic [7:0]       DATA_B,
    input  logic             clear,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             overflow
);

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int CW    = $clog2(WIDTH);
    localparam int RW    = $clog2(HEIGHT);

    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
    localparam logic [AW-1:0] BASE_INIT = AW'((HEIGHT - 1) * WIDTH);
    localparam logic [AW-1:0] ROW_STEP  = AW'(WIDTH);
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);

    state_t          state_r, state_s;
    logic [CW-1:0]   col_r, col_s;
    logic [RW-1:0]   row_r, row_s;
    logic [AW-1:0]   base_r, base_s;
    logic            overflow_r, overflow_s;
    logic            busy_r, done_r;
    logic            we_s;
    logic [AW-1:0]   waddr_s;
    logic [PIX_W-1:0] wdata_s;
    logic            rd_hit_s;
    logic            rd_valid_r;
    logic            rd_zero_r;
    logic [PIX_W-1:0] ram_q_s;

    // Next-state, counter advance and write-enable decode
    always_comb begin
        state_s    = state_r;
        col_s      = col_r;
        row_s      = row_r;
        base_s     = base_r;
        overflow_s = overflow_r;
        we_s       = 1'b0;
        if (clear) begin
            state_s    = IDLE;
            col_s      = {CW{1'b0}};
            row_s      = {RW{1'b0}};
            base_s     = BASE_INIT;
            overflow_s = 1'b0;
        end else begin
            case (state_r)
                IDLE, CAPTURE: begin
                    if (hsync) begin
                        we_s = 1'b1;
                        if (col_r == COL_LAST) begin
                            col_s  = {CW{1'b0}};
                            row_s  = row_r + 1'b1;
                            base_s = base_r - ROW_STEP;
                            if (row_r == ROW_LAST) begin
                                state_s = DONE;
                            end else begin
                                state_s = CAPTURE;
                            end
                        end else begin
                            col_s   = col_r + 1'b1;
                            state_s = CAPTURE;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                DONE: begin
                    if (hsync) begin
                        overflow_s = 1'b1;
                    end else begin
                        overflow_s = overflow_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Row base already holds (HEIGHT-1-row)*WIDTH, so only an add is needed
    assign waddr_s  = base_r + {{(AW-CW){1'b0}}, col_r};
    assign wdata_s  = pack_rgb(DATA_R, DATA_G, DATA_B);
    assign rd_hit_s = ({1'b0, rd_addr} < DEPTH_W);

    // Capture state, counters and status flags
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r    <= IDLE;
            col_r      <= {CW{1'b0}};
            row_r      <= {RW{1'b0}};
            base_r     <= BASE_INIT;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            col_r      <= col_s;
            row_r      <= row_s;
            base_r     <= base_s;
            overflow_r <= overflow_s;
            busy_r     <= (state_s == CAPTURE);
            done_r     <= (state_s == DONE);
        end
    end

    // Read-side qualifiers; rd_zero_r masks the unreset RAM output and out-of-range reads
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_valid_r <= 1'b0;
            rd_zero_r  <= 1'b1;
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                rd_zero_r <= !rd_hit_s;
            end
        end
    end

    frame_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (PIX_W)
    ) u_frame_ram (
        .clk   (HCLK),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .re    (rd_en && rd_hit_s),
        .raddr (rd_addr),
        .q     (ram_q_s)
    );

    assign rd_data    = rd_zero_r ? {PIX_W{1'b0}} : ram_q_s;
    assign rd_valid   = rd_valid_r;
    assign busy       = busy_r;
    assign frame_done = done_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_pixel_frame_capture.sv
// Directed bench for pixel_frame_capture at WIDTH=4, HEIGHT=3 with
// hand-computed expected buffer contents and flag timing.
module tb_pixel_frame_capture;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hsync = 1'b0;
    logic [7:0]    dr = 8'd0, dg = 8'd0, db = 8'd0;
    logic          clear = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = 4'd0;
    logic [23:0]   rd_data;
    logic          rd_valid, busy, frame_done, overflow;

    int passed = 0;
    int total  = 0;

    pixel_frame_capture #(.WIDTH(W), .HEIGHT(H)) dut (
        .HCLK       (clk),
        .HRESETn    (rst_n),
        .hsync      (hsync),
        .DATA_R     (dr),
        .DATA_G     (dg),
        .DATA_B     (db),
        .clear      (clear),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] px(input int k, input int off);
        return {8'(k + off), 8'(k + off + 1), 8'(k + off + 2)};
    endfunction

    task automatic beat(input logic [23:0] p);
        hsync = 1'b1;
        {dr, dg, db} = p;
        tick();
        hsync = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [23:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
        chk(tag, rd_data, exp);
        chk({tag, "_valid"}, {23'd0, rd_valid}, 24'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_rd_data", rd_data, 24'h0);
        chk("rst_rd_valid", {23'd0, rd_valid}, 24'd0);
        chk("rst_busy", {23'd0, busy}, 24'd0);
        chk("rst_done", {23'd0, frame_done}, 24'd0);
        chk("rst_ovf", {23'd0, overflow}, 24'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Frame 1: 12 back-to-back beats
        for (int k = 0; k < 12; k++) begin
            beat(px(k, 0));
            if (k == 0)  chk("f1_busy_b0", {23'd0, busy}, 24'd1);
            if (k == 10) chk("f1_done_early", {23'd0, frame_done}, 24'd0);
        end
        chk("f1_done", {23'd0, frame_done}, 24'd1);
        chk("f1_busy_off", {23'd0, busy}, 24'd0);
        rd_check("f1_a8", 4'd8, 24'h000102);
        rd_check("f1_a0", 4'd0, 24'h08090A);
        rd_check("f1_a11", 4'd11, 24'h030405);
        tick();
        chk("rd_idle_valid", {23'd0, rd_valid}, 24'd0);
        chk("rd_idle_hold", rd_data, 24'h030405);

        // Overflow in DONE, buffer untouched, then clear
        beat(24'hFFFFFF);
        beat(24'hFFFFFF);
        chk("ovf_set", {23'd0, overflow}, 24'd1);
        chk("ovf_done", {23'd0, frame_done}, 24'd1);
        rd_check("ovf_a8", 4'd8, 24'h000102);
        do_clear();
        chk("clr_ovf", {23'd0, overflow}, 24'd0);
        chk("clr_done", {23'd0, frame_done}, 24'd0);
        chk("clr_busy", {23'd0, busy}, 24'd0);

        // Frame 2: gaps of 1..3 idle cycles between beats, offset 0x20
        for (int k = 0; k < 12; k++) begin
            if (k == 11) chk("f2_done_early", {23'd0, frame_done}, 24'd0);
            beat(px(k, 32));
            for (int g = 0; g <= (k % 3); g++) tick();
        end
        chk("f2_done", {23'd0, frame_done}, 24'd1);
        rd_check("f2_a8", 4'd8, 24'h202122);
        rd_check("f2_a0", 4'd0, 24'h28292A);
        rd_check("f2_a11", 4'd11, 24'h232425);
        rd_check("f2_a5", 4'd5, 24'h252627);
        do_clear();

        // Clear coinciding with the sixth beat drops it
        for (int k = 0; k < 5; k++) beat(24'h111111);
        clear = 1'b1;
        beat(24'hAAAAAA);
        clear = 1'b0;
        chk("cd_busy_off", {23'd0, busy}, 24'd0);
        beat(24'h123456);
        chk("cd_busy", {23'd0, busy}, 24'd1);
        rd_check("cd_a8", 4'd8, 24'h123456);
        rd_check("cd_a5", 4'd5, 24'h252627);
        do_clear();

        // Asynchronous reset mid-frame with a read in flight
        for (int k = 0; k < 6; k++) beat(24'h222222);
        rd_en   = 1'b1;
        rd_addr = 4'd8;
        beat(24'h222222);
        rd_en = 1'b0;
        chk("ar_pre_valid", {23'd0, rd_valid}, 24'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rd_data", rd_data, 24'h0);
        chk("ar_rd_valid", {23'd0, rd_valid}, 24'd0);
        chk("ar_busy", {23'd0, busy}, 24'd0);
        chk("ar_done", {23'd0, frame_done}, 24'd0);
        chk("ar_ovf", {23'd0, overflow}, 24'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) beat(px(k, 64));
        chk("f3_done", {23'd0, frame_done}, 24'd1);
        rd_check("f3_a8", 4'd8, 24'h404142);
        rd_check("f3_a11", 4'd11, 24'h434445);
        rd_check("f3_a0", 4'd0, 24'h48494A);
        do_clear();

        // Read and write to the same address on one edge returns old data
        rd_en   = 1'b1;
        rd_addr = 4'd8;
        beat(24'h0A0B0C);
        rd_en = 1'b0;
        chk("rf_old", rd_data, 24'h404142);
        rd_check("rf_new", 4'd8, 24'h0A0B0C);

        // Out-of-range reads return zero with valid
        rd_check("oor_12", 4'd12, 24'h0);
        rd_check("oor_15", 4'd15, 24'h0);
        rd_check("oor_back", 4'd11, 24'h434445);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
